// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller: state encoding and
// the timer width helper.
package decoder_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } scan_state_e;

  // Counter must hold the larger of the two terminal values.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_timer.sv
// Clearable up-counter with a terminal-count compare against a run-time
// limit; shared by the blank and dwell phases of the scan controller.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d = clear_i ? '0 : cnt_q + W'(1);
  assign tc_o  = (cnt_q == limit_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 2-to-4 enabled line decoder: steps the channel code
// through 0..3 and gates EN so the code only moves while EN is low.
//
//   state  | meaning
//   IDLE   | EN low, waiting for RUN or a STEP pulse
//   BLANK  | EN low, guard interval before the dwell
//   ACTIVE | EN high, channel code frozen for the dwell
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic dir_i,
  input  logic step_i,
  output logic a0_o,
  output logic a1_o,
  output logic en_o,
  output logic scan_done_o
);

  localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_CYCLES - 1);

  scan_state_e      state_q;
  logic [1:0]       chan_q;
  logic [1:0]       chan_d;
  logic             wrap_d;
  logic             en_q;
  logic             done_q;
  logic             oneshot_q;

  logic             tmr_clear;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_tc;

  // The timer is held at zero in IDLE and restarts on every phase exit,
  // so each BLANK/ACTIVE entry begins counting from zero.
  assign tmr_clear = (state_q == ST_IDLE) || tmr_tc;
  assign tmr_limit = (state_q == ST_ACTIVE) ? DWELL_LIM : BLANK_LIM;

  scan_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (tmr_clear),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  assign chan_d = dir_i ? (chan_q - 2'd1) : (chan_q + 2'd1);
  assign wrap_d = dir_i ? (chan_q == 2'd0) : (chan_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      chan_q    <= 2'd0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run_i) begin
            state_q <= ST_BLANK;
          end else if (step_i) begin
            state_q   <= ST_BLANK;
            oneshot_q <= 1'b1;
          end
        end
        ST_BLANK: begin
          if (tmr_tc) begin
            state_q <= ST_ACTIVE;
            en_q    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          // Channel moves on the same edge EN falls, never mid-dwell.
          if (tmr_tc) begin
            chan_q <= chan_d;
            done_q <= wrap_d;
            en_q   <= 1'b0;
            if (oneshot_q) begin
              state_q   <= ST_IDLE;
              oneshot_q <= 1'b0;
            end else if (run_i) begin
              state_q <= ST_BLANK;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign a0_o        = chan_q[0];
  assign a1_o        = chan_q[1];
  assign en_o        = en_q;
  assign scan_done_o = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl with DWELL=4, BLANK=1.
module tb_decoder_scan_ctrl;

  localparam int DW = 4;
  localparam int BL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic dir = 1'b0;
  logic step = 1'b0;
  logic a0, a1, en, done;

  int checks = 0;
  int errors = 0;

  // Reference: remaining cycles in the current blank+dwell window.
  int mbusy = 0;
  int mch = 0;
  bit mos = 1'b0;
  bit mdone = 1'b0;

  typedef struct {
    logic       run;
    logic       dir;
    logic       step;
    logic       en;
    logic [1:0] ch;
    logic       done;
  } vec_t;

  vec_t tbl[25];

  decoder_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .run_i       (run),
    .dir_i       (dir),
    .step_i      (step),
    .a0_o        (a0),
    .a1_o        (a1),
    .en_o        (en),
    .scan_done_o (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit m_en();
    return (mbusy != 0) && (mbusy <= DW);
  endfunction

  task automatic model_reset();
    mbusy = 0; mch = 0; mos = 1'b0; mdone = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic d, input logic s);
    mdone = 1'b0;
    if (mbusy == 0) begin
      if (r) mbusy = BL + DW;
      else if (s) begin
        mbusy = BL + DW;
        mos = 1'b1;
      end
    end else begin
      mbusy--;
      if (mbusy == 0) begin
        mdone = d ? (mch == 0) : (mch == 3);
        mch = d ? (mch + 3) % 4 : (mch + 1) % 4;
        if (mos) mos = 1'b0;
        else if (r) mbusy = BL + DW;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic d, input logic s);
    run = r; dir = d; step = s;
    @(posedge clk);
    model_step(r, d, s);
    #1;
    chk("en", int'(en), int'(m_en()));
    chk("chan", int'({a1, a0}), mch);
    chk("scan_done", int'(done), int'(mdone));
  endtask

  // Advance until the model sits in a given channel/window position.
  task automatic wait_pos(input string name, input int ch, input int busy,
                          input logic r, input logic d);
    int n;
    n = 0;
    while (!(mch == ch && mbusy == busy) && n < 200) begin
      cycle(r, d, 1'b0);
      n++;
    end
    chk({name, "_reached"}, int'(n < 200), 1);
  endtask

  initial begin
    int en_cnt;
    logic rr, dd;

    for (int i = 0; i < 25; i++) begin
      tbl[i].run  = 1'b1;
      tbl[i].dir  = 1'b0;
      tbl[i].step = 1'b0;
      tbl[i].en   = ((i % 5) != 0);
      tbl[i].ch   = 2'((i / 5) % 4);
      tbl[i].done = (i == 20);
    end

    // 1: reset held, then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", int'(en), 0);
    chk("rst_chan", int'({a1, a0}), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);

    // 2: table-driven continuous up scan
    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].run, tbl[i].dir, tbl[i].step);
      chk("tbl_en", int'(en), int'(tbl[i].en));
      chk("tbl_chan", int'({a1, a0}), int'(tbl[i].ch));
      chk("tbl_done", int'(done), int'(tbl[i].done));
    end

    // 3: down scan, then DIR toggle mid-dwell on ch2
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 1'b0);
    wait_pos("dn_ch2", 2, 3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("dir_toggle_chan", int'({a1, a0}), 3);

    // 4: RUN dropped during the 2nd active cycle on ch2
    wait_pos("run_drop_ch2", 2, 3, 1'b1, 1'b0);
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (en) en_cnt++;
    end
    chk("run_drop_en_cycles", en_cnt, 2);
    chk("run_drop_chan", int'({a1, a0}), 3);

    // 5: STEP one-shots; STEP during ACTIVE is ignored
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0);
    end
    chk("step_pre_chan", int'({a1, a0}), 1);
    en_cnt = 0;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, (i == 2));
      if (en) begin
        en_cnt++;
        chk("step_dwell_chan", int'({a1, a0}), 1);
      end
    end
    chk("step_en_cycles", en_cnt, 4);
    chk("step_post_chan", int'({a1, a0}), 2);

    // 6: async reset mid-ACTIVE on ch3
    wait_pos("rst_ch3", 3, 3, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_en", int'(en), 0);
    chk("async_chan", int'({a1, a0}), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);

    // Randomized mix of RUN/DIR/STEP against the model
    rr = 1'b1; dd = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) rr = ~rr;
      if ($urandom_range(0, 9) == 0) dd = ~dd;
      cycle(rr, dd, ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
